// File: rtl/branch_pkg.sv
// branch_pkg: branch codes, code type and decode helpers shared by the branch unit
package branch_pkg;
  typedef logic [2:0] br_code_t;
  localparam br_code_t BR_NONE = 3'd0;
  localparam br_code_t BR_JAL  = 3'd1;
  localparam br_code_t BR_JALR = 3'd2;
  localparam br_code_t BR_EQ   = 3'd4;
  localparam br_code_t BR_NE   = 3'd5;
  localparam br_code_t BR_LT   = 3'd6;
  localparam br_code_t BR_GE   = 3'd7;
  function automatic logic is_cond(br_code_t c);
    return c[2];
  endfunction
  function automatic logic is_legal(br_code_t c);
    return c != 3'd3;
  endfunction
endpackage

// File: rtl/branch_unit_bp_if.sv
// branch_unit_bp_if: IFU lookup, EXU resolve and status signals; master = pipeline side, slave = branch unit
interface branch_unit_bp_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic [XLEN-1:0]        lookup_pc;
  logic                   lookup_taken;
  logic                   res_valid;
  logic [XLEN-1:0]        res_pc;
  branch_pkg::br_code_t   res_branch;
  logic                   res_zero;
  logic                   res_less;
  logic                   res_pred_taken;
  logic                   pc_a_src;
  logic                   pc_b_src;
  logic                   mispredict;
  logic                   flush;
  logic                   err;
  logic [PERF_W-1:0]      br_cnt;
  logic [PERF_W-1:0]      mis_cnt;
  modport master (
    output lookup_pc, res_valid, res_pc, res_branch, res_zero, res_less, res_pred_taken,
    input  lookup_taken, pc_a_src, pc_b_src, mispredict, flush, err, br_cnt, mis_cnt
  );
  modport slave (
    input  lookup_pc, res_valid, res_pc, res_branch, res_zero, res_less, res_pred_taken,
    output lookup_taken, pc_a_src, pc_b_src, mispredict, flush, err, br_cnt, mis_cnt
  );
endinterface

// File: rtl/bp_bht.sv
// bp_bht: saturating-counter table; rd_* async lookup of counter MSB, up_* saturating update
module bp_bht #(
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_BITS    = 2,
  localparam int IDXW       = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_taken,
  input  logic            up_en,
  input  logic [IDXW-1:0] up_idx,
  input  logic            up_taken
);
  localparam logic [CNT_BITS-1:0] INIT = (CNT_BITS)'((1 << (CNT_BITS - 1)) - 1);
  logic [CNT_BITS-1:0] cnt [BHT_ENTRIES];
  logic [CNT_BITS-1:0] cur, nxt;
  always_comb begin
    cur = cnt[up_idx];
    nxt = up_taken ? (&cur ? cur : cur + 1'b1) : (|cur ? cur - 1'b1 : cur);
  end
  assign rd_taken = cnt[rd_idx][CNT_BITS-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt[i] <= INIT;
    end else if (up_en) begin
      cnt[up_idx] <= nxt;
    end
  end
endmodule

// File: rtl/branch_unit_bp.sv
// branch_unit_bp: branch resolve, PC-select, BHT prediction, mispredict/flush, sticky err, perf counters
module branch_unit_bp
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_BITS    = 2,
  parameter int PERF_W      = 32
) (
  input logic             clk,
  input logic             rst,
  branch_unit_bp_if.slave bus
);
  localparam int IDXW = $clog2(BHT_ENTRIES);
  br_code_t code;
  logic taken, cond, legal, upd;
  logic unused_pc_bits;
  always_comb begin
    code  = bus.res_branch;
    cond  = is_cond(code);
    legal = is_legal(code);
    taken = code == BR_NONE ? 1'b0 :
            (code == BR_JAL || code == BR_JALR) ? 1'b1 :
            code == BR_EQ ? bus.res_zero :
            code == BR_NE ? ~bus.res_zero :
            code == BR_LT ? bus.res_less :
            code == BR_GE ? ~bus.res_less : 1'b0;
    upd   = bus.res_valid & cond & legal;
  end
  assign bus.pc_a_src   = bus.res_valid & ~rst & taken & legal;
  assign bus.pc_b_src   = bus.res_valid & ~rst & (code == BR_JALR);
  assign bus.mispredict = bus.res_valid & cond & (taken != bus.res_pred_taken);
  assign unused_pc_bits = ^{bus.res_pc[XLEN-1:IDXW+2], bus.res_pc[1:0],
                            bus.lookup_pc[XLEN-1:IDXW+2], bus.lookup_pc[1:0]};
  bp_bht #(.BHT_ENTRIES(BHT_ENTRIES), .CNT_BITS(CNT_BITS)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.lookup_pc[IDXW+1:2]),
    .rd_taken (bus.lookup_taken),
    .up_en    (upd),
    .up_idx   (bus.res_pc[IDXW+1:2]),
    .up_taken (taken)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.flush   <= 1'b0;
      bus.err     <= 1'b0;
      bus.br_cnt  <= '0;
      bus.mis_cnt <= '0;
    end else begin
      bus.flush <= bus.mispredict;
      if (bus.res_valid && !legal) bus.err <= 1'b1;
      if (upd) bus.br_cnt <= bus.br_cnt + 1'b1;
      if (bus.mispredict) bus.mis_cnt <= bus.mis_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_unit_bp.sv
// tb_branch_unit_bp: directed table and sequence checks of branch_unit_bp
module tb_branch_unit_bp;
  import branch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  branch_unit_bp_if #(.XLEN(32), .PERF_W(32)) bus();
  branch_unit_bp #(.XLEN(32), .BHT_ENTRIES(16), .CNT_BITS(2), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  typedef struct packed {
    logic     v;
    br_code_t code;
    logic     z;
    logic     l;
    logic     p;
    logic     a;
    logic     b;
    logic     m;
  } vec_t;
  vec_t vecs [14];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input br_code_t c,
                       input logic z, input logic l, input logic p);
    bus.res_valid = v;
    bus.res_pc = pc;
    bus.res_branch = c;
    bus.res_zero = z;
    bus.res_less = l;
    bus.res_pred_taken = p;
    #1;
  endtask
  task automatic idle;
    drive(1'b0, 32'h0, BR_NONE, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    vecs = '{
      '{1'b1, BR_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, BR_JAL,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, BR_JALR, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, BR_EQ,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, BR_EQ,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, BR_NE,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, BR_NE,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, BR_LT,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, BR_LT,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b1, BR_GE,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, BR_GE,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, BR_EQ,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, BR_JALR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'd3,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
    };
    bus.lookup_pc = 32'h8000_0000;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset lookup_taken", bus.lookup_taken, 0);
    chk("reset err", bus.err, 0);
    chk("reset br_cnt", bus.br_cnt, 0);
    chk("reset mis_cnt", bus.mis_cnt, 0);
    chk("reset flush", bus.flush, 0);
    drive(1'b1, 32'h8000_0010, BR_EQ, 1'b1, 1'b0, 1'b0);
    chk("eq pc_a_src", bus.pc_a_src, 1);
    chk("eq pc_b_src", bus.pc_b_src, 0);
    chk("eq mispredict", bus.mispredict, 1);
    tick();
    idle();
    bus.lookup_pc = 32'h8000_0010;
    #1;
    chk("eq flush", bus.flush, 1);
    chk("eq br_cnt", bus.br_cnt, 1);
    chk("eq mis_cnt", bus.mis_cnt, 1);
    chk("eq lookup 10", bus.lookup_taken, 1);
    tick();
    chk("flush one pulse", bus.flush, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0010, BR_EQ, 1'b1, 1'b0, 1'b1);
      chk("taken no mispredict", bus.mispredict, 0);
      tick();
    end
    idle();
    chk("sat br_cnt", bus.br_cnt, 4);
    chk("sat mis_cnt", bus.mis_cnt, 1);
    chk("sat flush", bus.flush, 0);
    drive(1'b1, 32'h8000_0010, BR_GE, 1'b0, 1'b1, 1'b1);
    chk("ge mispredict", bus.mispredict, 1);
    tick();
    idle();
    chk("after sat dec lookup", bus.lookup_taken, 1);
    drive(1'b1, 32'h8000_0010, BR_GE, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    chk("second dec lookup", bus.lookup_taken, 0);
    drive(1'b1, 32'h8000_0010, BR_EQ, 1'b0, 1'b0, 1'b1);
    chk("b2b mis 1", bus.mispredict, 1);
    tick();
    drive(1'b1, 32'h8000_0010, BR_NE, 1'b1, 1'b0, 1'b1);
    chk("b2b mis 2", bus.mispredict, 1);
    chk("b2b flush 1", bus.flush, 1);
    tick();
    idle();
    chk("b2b flush 2", bus.flush, 1);
    tick();
    chk("b2b flush end", bus.flush, 0);
    chk("b2b br_cnt", bus.br_cnt, 8);
    chk("b2b mis_cnt", bus.mis_cnt, 5);
    drive(1'b1, 32'h8000_0010, BR_EQ, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("floor then inc lookup", bus.lookup_taken, 0);
    drive(1'b1, 32'h8000_0010, BR_JALR, 1'b0, 1'b0, 1'b0);
    chk("jalr pc_a_src", bus.pc_a_src, 1);
    chk("jalr pc_b_src", bus.pc_b_src, 1);
    chk("jalr mispredict", bus.mispredict, 0);
    tick();
    idle();
    chk("jalr br_cnt", bus.br_cnt, 9);
    chk("jalr mis_cnt", bus.mis_cnt, 6);
    chk("jalr flush", bus.flush, 0);
    drive(1'b1, 32'h8000_0010, BR_EQ, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    chk("jalr no bht change", bus.lookup_taken, 1);
    drive(1'b1, 32'h8000_0010, 3'd3, 1'b1, 1'b1, 1'b0);
    chk("illegal pc_a_src", bus.pc_a_src, 0);
    chk("illegal pc_b_src", bus.pc_b_src, 0);
    chk("illegal mispredict", bus.mispredict, 0);
    tick();
    idle();
    chk("illegal err", bus.err, 1);
    chk("illegal br_cnt", bus.br_cnt, 10);
    chk("illegal lookup", bus.lookup_taken, 1);
    tick();
    tick();
    chk("err sticky", bus.err, 1);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, 32'h8000_0100, vecs[i].code, vecs[i].z, vecs[i].l, vecs[i].p);
      chk($sformatf("vec%0d pc_a_src", i), bus.pc_a_src, vecs[i].a);
      chk($sformatf("vec%0d pc_b_src", i), bus.pc_b_src, vecs[i].b);
      chk($sformatf("vec%0d mispredict", i), bus.mispredict, vecs[i].m);
      tick();
    end
    idle();
    chk("table br_cnt", bus.br_cnt, 18);
    chk("table mis_cnt", bus.mis_cnt, 9);
    rst = 1'b1;
    drive(1'b1, 32'h8000_0010, BR_EQ, 1'b1, 1'b0, 1'b0);
    chk("rst pc_a_src", bus.pc_a_src, 0);
    chk("rst pc_b_src", bus.pc_b_src, 0);
    tick();
    rst = 1'b0;
    idle();
    chk("post rst err", bus.err, 0);
    chk("post rst br_cnt", bus.br_cnt, 0);
    chk("post rst mis_cnt", bus.mis_cnt, 0);
    chk("post rst flush", bus.flush, 0);
    for (int i = 0; i < 16; i++) begin
      bus.lookup_pc = 32'h8000_0000 + 32'(i * 4);
      #1;
      chk($sformatf("init entry%0d", i), bus.lookup_taken, 0);
      drive(1'b1, bus.lookup_pc, BR_EQ, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      chk($sformatf("init+1 entry%0d", i), bus.lookup_taken, 1);
    end
    chk("init loop br_cnt", bus.br_cnt, 16);
    bus.lookup_pc = 32'h8000_0010;
    drive(1'b1, 32'h8000_0010, BR_GE, 1'b0, 1'b1, 1'b0);
    chk("no bypass same cycle", bus.lookup_taken, 1);
    tick();
    idle();
    chk("no bypass next cycle", bus.lookup_taken, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_unit_bp.md
Name: branch_unit_bp

Overview:
- Parametrised successor to the combinational branch-condition decoder.
- Resolves branch/jump outcome from ALU flags (zero, less) and drives the PC-select pair (pc_a_src, pc_b_src).
- Adds a BHT_ENTRIES-deep table of saturating counters for fetch-side taken prediction, mispredict detection against the prediction carried down the pipe, sticky illegal-code error, and performance counters.
- Sits between EXU (resolve port) and IFU (lookup port).

Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 16, number of predictor entries; power of two, at least 2.
- CNT_BITS, 2, saturating counter width; at least 1.
- PERF_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- lookup_pc  in  XLEN  fetch PC to predict.
- lookup_taken  out  1  predicted taken for lookup_pc.
- res_valid  in  1  resolve port carries a valid instruction this cycle.
- res_pc  in  XLEN  PC of the resolving instruction.
- res_branch  in  3  branch code (see package).
- res_zero  in  1  ALU zero flag.
- res_less  in  1  ALU less flag.
- res_pred_taken  in  1  prediction made at fetch for this instruction.
- pc_a_src  out  1  1 = PC-A operand is the immediate (branch/jump taken).
- pc_b_src  out  1  1 = PC-B operand is rs1 (JALR).
- mispredict  out  1  conditional-branch outcome differs from res_pred_taken.
- flush  out  1  registered copy of mispredict, one cycle later.
- err  out  1  sticky illegal-code flag.
- br_cnt  out  PERF_W  resolved conditional branches.
- mis_cnt  out  PERF_W  mispredicted conditional branches.

Behaviour:
- Index: idx = pc[IDXW+1:2], where IDXW = log2(BHT_ENTRIES).
- Branch codes:
  - NONE=0, JAL=1, JALR=2, EQ=4, NE=5, LT=6, GE=7.
  - 3 is illegal.
  - cond = codes 4..7.
- taken (combinational):
  - NONE → 0.
  - JAL, JALR → 1.
  - EQ → zero; NE → ~zero.
  - LT → less; GE → ~less.
- Resolve outputs (combinational, same cycle as res_valid):
  - pc_a_src = res_valid & taken & legal.
  - pc_b_src = res_valid & (code==JALR).
  - Both are 0 when res_valid=0, when rst=1, or when the code is illegal.
- mispredict = res_valid & cond & (taken != res_pred_taken). JAL/JALR never flag a mispredict.
- flush:
  - Registered; flush(t+1) = mispredict(t).
  - Exactly one-cycle pulse per mispredict; back-to-back mispredicts give back-to-back pulses.
- BHT:
  - Reset: every counter = 2^(CNT_BITS-1)-1 (weakly not-taken; 01 for CNT_BITS=2).
  - Update at clk edge when res_valid & cond & legal: taken → increment, saturating at all-ones; not taken → decrement, saturating at 0.
  - NONE/JAL/JALR/illegal codes do not update.
- lookup_taken:
  - Combinational: MSB of counter[idx(lookup_pc)].
  - Same-cycle update to the same index is not bypassed; lookup returns the pre-update value.
- err:
  - Set at clk edge when res_valid & code==3; held until rst.
  - An illegal cycle changes no BHT entry and no counter.
- Performance counters (both 0 at reset, wrap modulo 2^PERF_W without saturation):
  - br_cnt += 1 on each res_valid & cond.
  - mis_cnt += 1 on each mispredict.
- Reset: all registered state returns to reset values at the next edge, mid-operation included. flush=0, err=0, counters=0, BHT re-initialised. A resolve presented in the reset cycle is discarded.

Decomposition:
- Package branch_pkg holds:
  - BR_NONE/JAL/JALR/EQ/NE/LT/GE localparams.
  - br_code_t 3-bit typedef.
  - is_cond() function.
  - is_legal() function.
- Sub-module bp_bht (BHT_ENTRIES, CNT_BITS) provides:
  - Counter array with reset init.
  - One async read port.
  - One saturating update port.

Test Plan:
- Reset, then lookup_pc=0x80000000 → lookup_taken=0, err=0, br_cnt=mis_cnt=0, flush=0.
- res_valid, pc=0x80000010, EQ, zero=1, pred=0 → pc_a_src=1, pc_b_src=0, mispredict=1; next cycle flush=1, br_cnt=1, mis_cnt=1. Entry idx 4 becomes 10, so lookup_taken=1 for 0x80000010.
- Same PC resolved taken 3 more times → counter saturates at 11. Then 1 not-taken (GE, less=1) → counter 10, lookup_taken stays 1.
- JALR with res_pred_taken=0 → pc_a_src=1, pc_b_src=1, mispredict=0, no BHT or counter change.
- Code 3 with res_valid=1 → pc_a_src=pc_b_src=0 and err=1 sticky. Then rst for 1 cycle → err=0 and all BHT entries back to 01.
- Same cycle: update idx 4 not-taken while lookup_pc maps to idx 4 at 10 → lookup_taken=1 that cycle, 0 the next.
